// File: rtl/sec_pkg.sv
// sec_pkg: shared widths, codeword type and the SEC check-bit equations.
package sec_pkg;
    localparam int DATA_W = 32;
    localparam int CHK_W  = 8;
    localparam int CODE_W = 40;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CHK_W-1:0]  chk;
    } code_t;
    function automatic logic [7:0] sec_q(input logic [31:0] d);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = ^d[4*k +: 4];
        return r;
    endfunction
    // col[3:0] covers d[15:0], col[7:4] covers d[31:16]
    function automatic logic [7:0] sec_col(input logic [31:0] d);
        logic [7:0] r;
        for (int j = 0; j < 4; j++) begin
            r[j]   = d[j] ^ d[j+4] ^ d[j+8] ^ d[j+12];
            r[j+4] = d[j+16] ^ d[j+20] ^ d[j+24] ^ d[j+28];
        end
        return r;
    endfunction
    function automatic logic [7:0] sec_fin(input logic [7:0] q, input logic [7:0] col);
        return col ^ {q[1]^q[3], q[0]^q[2], q[2]^q[3], q[0]^q[1],
                      q[5]^q[7], q[4]^q[6], q[6]^q[7], q[4]^q[5]};
    endfunction
    function automatic logic [7:0] sec_chk(input logic [31:0] d);
        return sec_fin(sec_q(d), sec_col(d));
    endfunction
endpackage

// File: rtl/sec_encoder_pipe_if.sv
// sec_encoder_pipe_if: input word and output codeword valid/ready streams.
interface sec_encoder_pipe_if;
    logic                         in_valid;
    logic                         in_ready;
    logic [sec_pkg::DATA_W-1:0]   in_data;
    logic [sec_pkg::CODE_W-1:0]   in_inj;
    logic                         out_valid;
    logic                         out_ready;
    logic [sec_pkg::DATA_W-1:0]   out_data;
    logic [sec_pkg::CHK_W-1:0]    out_chk;
    logic                         out_chk_en;
    modport slave (input in_valid, in_data, in_inj, out_ready,
                   output in_ready, out_valid, out_data, out_chk, out_chk_en);
    modport master (output in_valid, in_data, in_inj, out_ready,
                    input in_ready, out_valid, out_data, out_chk, out_chk_en);
endinterface

// File: rtl/sec_chk_gen.sv
// sec_chk_gen: check-bit logic split into a parity precompute half (before S1)
// and a final XOR half (between S1 and S2).
module sec_chk_gen
    import sec_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    output logic [7:0]        q,
    output logic [7:0]        col,
    input  logic [7:0]        q_r,
    input  logic [7:0]        col_r,
    output logic [CHK_W-1:0]  c
);
    assign q   = sec_q(d);
    assign col = sec_col(d);
    assign c   = sec_fin(q_r, col_r);
endmodule

// File: rtl/sec_encoder_pipe.sv
// sec_encoder_pipe: two-stage SEC check-bit generator with optional fault injection.
module sec_encoder_pipe
    import sec_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter bit INJ_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sec_encoder_pipe_if.slave bus,
    output logic [CNT_W-1:0]  word_cnt
);
    logic              s1_valid, ld2, acc;
    logic [DATA_W-1:0] s1_data;
    logic [CODE_W-1:0] s1_inj, inj;
    logic [7:0]        q, col, s1_q, s1_col;
    logic [CHK_W-1:0]  c;
    assign ld2            = !bus.out_valid || bus.out_ready;
    assign bus.in_ready   = !s1_valid || ld2;
    assign acc            = bus.in_valid && bus.in_ready;
    assign inj            = INJ_EN ? bus.in_inj : '0;
    assign bus.out_chk_en = bus.out_valid;
    sec_chk_gen u_gen (.d(bus.in_data), .q, .col, .q_r(s1_q), .col_r(s1_col), .c);
    // in_ready implies S1 is empty or draining, so a bubble may clear it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_inj   <= '0;
            s1_q     <= '0;
            s1_col   <= '0;
            word_cnt <= '0;
        end else begin
            if (bus.in_ready) s1_valid <= bus.in_valid;
            if (acc) begin
                s1_data  <= bus.in_data;
                s1_inj   <= inj;
                s1_q     <= q;
                s1_col   <= col;
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_chk   <= '0;
        end else if (ld2) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_data <= s1_data ^ s1_inj[DATA_W-1:0];
                bus.out_chk  <= c ^ s1_inj[CODE_W-1:DATA_W];
            end
        end
    end
endmodule

// File: tb/tb_sec_encoder_pipe.sv
// tb_sec_encoder_pipe: table vectors, stall/reset sequences and a random stream
// checked through an in-order scoreboard; a second INJ_EN=0, CNT_W=2 instance rides along.
module tb_sec_encoder_pipe;
    import sec_pkg::*;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    sec_encoder_pipe_if bus();
    sec_encoder_pipe_if bus2();
    logic [15:0] word_cnt;
    logic [1:0]  word_cnt2;
    sec_encoder_pipe #(.CNT_W(16), .INJ_EN(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .word_cnt(word_cnt));
    sec_encoder_pipe #(.CNT_W(2), .INJ_EN(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .word_cnt(word_cnt2));
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_data   = bus.in_data;
    assign bus2.in_inj    = bus.in_inj;
    assign bus2.out_ready = bus.out_ready;
    typedef struct { code_t exp; code_t raw; } sb_t;
    typedef struct { logic [31:0] d; logic [39:0] inj; logic [7:0] chk; } vec_t;
    sb_t  sb[$];
    sb_t  cur;
    vec_t vt[7];
    int   checks = 0, errors = 0, n_acc = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic send(input logic [31:0] d, input logic [39:0] inj, input logic [7:0] c);
        bus.in_valid     = 1'b1;
        bus.in_data      = d;
        bus.in_inj       = inj;
        cur.exp.data     = d ^ inj[31:0];
        cur.exp.chk      = c ^ inj[39:32];
        cur.raw.data     = d;
        cur.raw.chk      = c;
    endtask
    // sample mid-cycle, score handshakes, then advance to the next falling edge
    task automatic tick();
        sb_t e;
        #1;
        if (bus.in_valid && bus.in_ready) begin
            sb.push_back(cur);
            n_acc++;
        end
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = sb.pop_front();
                chk("out_data", bus.out_data, e.exp.data);
                chk("out_chk", bus.out_chk, e.exp.chk);
                chk("out_chk_en", bus.out_chk_en, 1);
                chk("noinj_valid", bus2.out_valid, 1);
                chk("noinj_data", bus2.out_data, e.raw.data);
                chk("noinj_chk", bus2.out_chk, e.raw.chk);
            end
        end
        @(negedge clk);
    endtask
    initial begin
        int base;
        vt = '{'{32'h0000_0001, 40'h0, 8'h51}, '{32'hFFFF_FFFF, 40'h0, 8'h00},
               '{32'h0000_000F, 40'h0, 8'h0F}, '{32'h0001_0000, 40'h0, 8'h15},
               '{32'h0000_0000, 40'h0, 8'h00}, '{32'h0000_0001, 40'h00_0000_0002, 8'h51},
               '{32'h0000_0000, 40'h80_0000_0000, 8'h00}};
        bus.in_valid = 0; bus.in_data = 0; bus.in_inj = 0; bus.out_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_chk", bus.out_chk, 0);
        chk("rst_chk_en", bus.out_chk_en, 0);
        chk("rst_word_cnt", word_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #1 chk("rel_in_ready", bus.in_ready, 1);
        @(negedge clk);
        send(32'h1, 40'h0, 8'h51);
        tick();
        bus.in_valid = 0;
        #1 chk("lat1_out_valid", bus.out_valid, 0);
        @(negedge clk);
        #1 chk("lat2_out_valid", bus.out_valid, 1);
        tick();
        foreach (vt[i]) begin
            send(vt[i].d, vt[i].inj, vt[i].chk);
            tick();
        end
        bus.in_valid = 0;
        repeat (3) tick();
        chk("table_drained", sb.size(), 0);
        bus.out_ready = 0;
        base = n_acc;
        for (int i = 0; i < 5; i++) begin
            send(32'h1000 + i, 40'h0, sec_chk(32'h1000 + i));
            tick();
        end
        #1;
        chk("stall_accepts", n_acc - base, 2);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        chk("stall_out_data", bus.out_data, 32'h1000);
        chk("stall_out_chk", bus.out_chk, sec_chk(32'h1000));
        bus.in_valid = 0;
        bus.out_ready = 1;
        tick();
        #1 chk("stall_second_valid", bus.out_valid, 1);
        tick();
        chk("stall_drained", sb.size(), 0);
        base = n_acc;
        for (int cyc = 0; cyc < 20000 && n_acc - base < 1000; cyc++) begin
            logic [31:0] d;
            d = $urandom;
            send(d, 40'h0, sec_chk(d));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = $urandom_range(0, 1);
            tick();
        end
        bus.in_valid = 0;
        bus.out_ready = 1;
        repeat (4) tick();
        chk("rand_accepts", n_acc - base, 1000);
        chk("rand_drained", sb.size(), 0);
        chk("word_cnt", word_cnt, n_acc);
        chk("word_cnt_wrap", word_cnt2, n_acc % 4);
        bus.out_ready = 0;
        send(32'hDEAD_0000, 40'h0, sec_chk(32'hDEAD_0000));
        tick();
        send(32'hBEEF_0000, 40'h0, sec_chk(32'hBEEF_0000));
        tick();
        bus.in_valid = 0;
        #1;
        chk("full_out_valid", bus.out_valid, 1);
        chk("full_in_ready", bus.in_ready, 0);
        #2 rst_n = 0;
        #1;
        chk("async_out_valid", bus.out_valid, 0);
        chk("async_out_data", bus.out_data, 0);
        chk("async_out_chk", bus.out_chk, 0);
        chk("async_word_cnt", word_cnt, 0);
        sb.delete();
        n_acc = 0;
        @(negedge clk);
        rst_n = 1;
        bus.out_ready = 1;
        @(negedge clk);
        #1 chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);
        @(negedge clk);
        send(32'h0000_000F, 40'h0, 8'h0F);
        tick();
        bus.in_valid = 0;
        repeat (3) tick();
        chk("post_rst_drained", sb.size(), 0);
        chk("post_rst_word_cnt", word_cnt, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
